// File: rtl/jt51_kon_sched.sv
// Key-on scheduler: queues CPU key-on writes and applies each over a whole
// 32-slot round so the envelope stage's key-on edge detector sees every change.
module jt51_kon_sched #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       zero,
    input  logic       kon_we,
    input  logic [2:0] kon_ch,
    input  logic [3:0] kon_op,
    input  logic       csm_req,
    output logic       keyon_II,
    output logic [4:0] slot,
    output logic       busy,
    output logic       full,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        APPLY = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t         state, state_nx;
    logic [4:0]     pass_cnt, pass_cnt_nx;
    logic           pass_cmd, pass_cmd_nx;
    logic           csm_pend, csm_act, csm_act_nx;
    logic [31:0]    kon_state, kon_nx;

    logic [6:0]     fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr, head_idx;
    logic [AW:0]    count, count_nx, count_left;
    logic [2:0]     head_ch;
    logic [3:0]     head_op;

    logic           last, pop, push, remain, start;
    logic [4:0]     slot_nx;

    // Datapath decisions shared by the FSM and the FIFO.
    always_comb begin
        last       = (state == APPLY) && (pass_cnt == 5'd31);
        pop        = last && pass_cmd;
        push       = kon_we && (!full || pop);
        count_left = count - {{AW{1'b0}}, pop};
        // A write landing in this cycle is not counted: the FSM sees it next cycle.
        remain     = (count_left != '0);
        start      = zero && ((state == WAIT0) || (last && (remain || csm_pend)));
        head_idx   = rd_ptr + {{(AW-1){1'b0}}, pop};
        {head_ch, head_op} = fifo_mem[head_idx];
        count_nx   = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        slot_nx    = zero ? 5'd1 : slot + 5'd1;
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nx    = state;
        pass_cnt_nx = pass_cnt;
        pass_cmd_nx = pass_cmd;
        csm_act_nx  = csm_act;
        case (state)
            IDLE: begin
                if (count != '0 || csm_pend)
                    state_nx = WAIT0;
            end
            APPLY: begin
                pass_cnt_nx = pass_cnt + 5'd1;
                if (last) begin
                    csm_act_nx  = 1'b0;
                    pass_cmd_nx = 1'b0;
                    state_nx    = (remain || csm_pend) ? WAIT0 : IDLE;
                end
            end
            default: ;
        endcase
        // A pass ending on a zero pulse chains straight into the next one.
        if (start) begin
            state_nx    = APPLY;
            pass_cnt_nx = 5'd0;
            pass_cmd_nx = remain;
            csm_act_nx  = csm_pend;
        end
    end

    always_comb begin
        kon_nx = kon_state;
        if (start && remain) begin
            for (int s = 0; s < 32; s++) begin
                if (3'(s) == head_ch)
                    kon_nx[5'(s)] = head_op[2'(s >> 3)];
            end
        end
    end

    assign busy = (state != IDLE) || (count != '0);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= 5'd0;
            state     <= IDLE;
            pass_cnt  <= 5'd0;
            pass_cmd  <= 1'b0;
            csm_pend  <= 1'b0;
            csm_act   <= 1'b0;
            kon_state <= 32'd0;
            keyon_II  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            slot      <= slot_nx;
            state     <= state_nx;
            pass_cnt  <= pass_cnt_nx;
            pass_cmd  <= pass_cmd_nx;
            csm_pend  <= (csm_pend && !start) || csm_req;
            csm_act   <= csm_act_nx;
            kon_state <= kon_nx;
            // Look ahead one slot so a freshly applied bit shows without a bubble.
            keyon_II  <= kon_nx[slot_nx] | csm_act_nx;
            if (push)
                wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            if (pop)
                rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            count     <= count_nx;
            full      <= (count_nx == FULL_CNT);
            ovf       <= ovf || (kon_we && !push);
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {kon_ch, kon_op};
    end

endmodule

// File: tb/tb_jt51_kon_sched.sv
// Self-checking bench for jt51_kon_sched: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_jt51_kon_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       zero;
    logic       kon_we;
    logic [2:0] kon_ch;
    logic [3:0] kon_op;
    logic       csm_req;
    logic       keyon_II;
    logic [4:0] slot;
    logic       busy;
    logic       full;
    logic       ovf;

    jt51_kon_sched #(.DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .zero     (zero),
        .kon_we   (kon_we),
        .kon_ch   (kon_ch),
        .kon_op   (kon_op),
        .csm_req  (csm_req),
        .keyon_II (keyon_II),
        .slot     (slot),
        .busy     (busy),
        .full     (full),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic zero_en = 1'b1;

    // Reference model: a command queue, a 32-bit key-on image and a pass countdown.
    logic [4:0]  m_slot;
    logic [31:0] m_kon;
    logic [6:0]  m_q[$];
    logic        m_ovf, m_pend, m_wait, m_pcmd, m_pcsm, m_keyon;
    int          m_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 5'd0; m_kon = 32'd0; m_q.delete();
        m_ovf = 1'b0; m_pend = 1'b0; m_wait = 1'b0;
        m_pcmd = 1'b0; m_pcsm = 1'b0; m_keyon = 1'b0; m_left = 0;
    endtask

    task automatic model_step(input logic we, input logic [2:0] ch, input logic [3:0] op,
                              input logic csm, input logic z);
        int   cnt, left_after;
        logic last, pop, start, idle, was_pend;
        logic [6:0] e;
        cnt        = m_q.size();
        last       = (m_left == 1);
        pop        = last && m_pcmd;
        left_after = cnt - (pop ? 1 : 0);
        start      = z && (m_wait || (last && (left_after > 0 || m_pend)));
        idle       = (m_left == 0) && !m_wait;
        was_pend   = m_pend;
        if (pop) void'(m_q.pop_front());
        if (start) begin
            m_pcmd = (left_after > 0);
            m_pcsm = was_pend;
            m_left = 32;
            m_wait = 1'b0;
            if (m_pcmd) begin
                e = m_q[0];
                for (int k = 0; k < 4; k++) m_kon[k*8 + int'(e[6:4])] = e[k];
            end
        end else if (last) begin
            m_left = 0; m_pcsm = 1'b0; m_pcmd = 1'b0;
            m_wait = (left_after > 0) || was_pend;
        end else if (m_left > 0) begin
            m_left--;
        end else if (idle) begin
            m_wait = (cnt > 0) || was_pend;
        end
        if (we) begin
            if (cnt < 4 || pop) m_q.push_back({ch, op});
            else m_ovf = 1'b1;
        end
        m_pend  = (start ? 1'b0 : was_pend) | csm;
        m_slot  = z ? 5'd1 : m_slot + 5'd1;
        m_keyon = m_kon[m_slot] | m_pcsm;
    endtask

    task automatic check_outputs();
        check("keyon_II", 32'(keyon_II), 32'(m_keyon));
        check("slot",     32'(slot),     32'(m_slot));
        check("busy",     32'(busy),     32'(m_wait || m_left > 0 || m_q.size() > 0));
        check("full",     32'(full),     32'(m_q.size() == 4));
        check("ovf",      32'(ovf),      32'(m_ovf));
    endtask

    task automatic tick(input logic we, input logic [2:0] ch, input logic [3:0] op, input logic csm);
        zero    = zero_en && (m_slot == 5'd0);
        kon_we  = we;
        kon_ch  = ch;
        kon_op  = op;
        csm_req = csm;
        model_step(we, ch, op, csm, zero);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 4'd0, 1'b0);
    endtask

    task automatic align();
        for (int i = 0; i < 32 && m_slot != 5'd0; i++) tick(1'b0, 3'd0, 4'd0, 1'b0);
    endtask

    // Collects keyon_II for one round; call with the current cycle at slot 0.
    task automatic capture(output logic [31:0] v);
        v = 32'd0;
        for (int i = 0; i < 32; i++) begin
            v[m_slot] = keyon_II;
            tick(1'b0, 3'd0, 4'd0, 1'b0);
        end
    endtask

    task automatic do_reset();
        kon_we = 1'b0; csm_req = 1'b0; zero = 1'b0; kon_ch = 3'd0; kon_op = 4'd0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst keyon_II", 32'(keyon_II), 32'd0);
        check("rst slot",     32'(slot),     32'd0);
        check("rst busy",     32'(busy),     32'd0);
        check("rst full",     32'(full),     32'd0);
        check("rst ovf",      32'(ovf),      32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;

        // Basic key-on: ch2, all operators -> slots 2, 10, 18, 26.
        do_reset();
        idle(3);
        tick(1'b1, 3'd2, 4'b1111, 1'b0);
        align();
        capture(v); check("t1 round1", v, 32'h0404_0404);
        capture(v); check("t1 round2", v, 32'h0404_0404);
        check("t1 busy idle", 32'(busy), 32'd0);

        // Back-to-back writes on ch1: slot 1 high for one round only.
        do_reset();
        idle(3);
        tick(1'b1, 3'd1, 4'b0001, 1'b0);
        tick(1'b1, 3'd1, 4'b0000, 1'b0);
        align();
        capture(v); check("t2 round1", v, 32'h0000_0002);
        capture(v); check("t2 round2", v, 32'h0000_0000);

        // Overflow with no zero pulses, then four queued commands over four rounds.
        do_reset();
        zero_en = 1'b0;
        tick(1'b1, 3'd3, 4'b0001, 1'b0);
        tick(1'b1, 3'd4, 4'b0010, 1'b0);
        tick(1'b1, 3'd5, 4'b0100, 1'b0);
        tick(1'b1, 3'd6, 4'b1000, 1'b0);
        check("t3 full", 32'(full), 32'd1);
        check("t3 no ovf yet", 32'(ovf), 32'd0);
        tick(1'b1, 3'd7, 4'b1111, 1'b0);
        check("t3 ovf", 32'(ovf), 32'd1);
        idle(5);
        zero_en = 1'b1;
        align();
        capture(v); check("t3 round1", v, 32'h0000_0008);
        capture(v); check("t3 round2", v, 32'h0000_1008);
        capture(v); check("t3 round3", v, 32'h0020_1008);
        capture(v); check("t3 round4", v, 32'h4020_1008);
        capture(v); check("t3 round5", v, 32'h4020_1008);
        check("t3 busy idle", 32'(busy), 32'd0);
        check("t3 ovf sticky", 32'(ovf), 32'd1);

        // CSM burst: two merged requests give one 32-slot window (slots 1..31, then slot 0).
        do_reset();
        idle(2);
        tick(1'b0, 3'd0, 4'd0, 1'b1);
        idle(3);
        tick(1'b0, 3'd0, 4'd0, 1'b1);
        align();
        capture(v); check("t4 round1", v, 32'hFFFF_FFFE);
        capture(v); check("t4 round2", v, 32'h0000_0001);
        capture(v); check("t4 round3", v, 32'h0000_0000);

        // CSM together with ch5/C2: burst, then slot 29 alone.
        do_reset();
        idle(2);
        tick(1'b1, 3'd5, 4'b1000, 1'b1);
        align();
        capture(v); check("t5 round1", v, 32'hFFFF_FFFE);
        capture(v); check("t5 round2", v, 32'h2000_0001);
        capture(v); check("t5 round3", v, 32'h2000_0000);

        // Reset at slot 12 of a pass: everything clears and the queue is lost.
        do_reset();
        idle(2);
        tick(1'b1, 3'd0, 4'b1111, 1'b0);
        tick(1'b1, 3'd7, 4'b1111, 1'b0);
        align();
        idle(12);
        check("t6 slot before rst", 32'(slot), 32'd12);
        check("t6 busy before rst", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        kon_we = 1'b0; csm_req = 1'b0; zero = 1'b0;
        #1;
        check("t6 rst keyon_II", 32'(keyon_II), 32'd0);
        check("t6 rst slot",     32'(slot),     32'd0);
        check("t6 rst busy",     32'(busy),     32'd0);
        check("t6 rst full",     32'(full),     32'd0);
        check("t6 rst ovf",      32'(ovf),      32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        capture(v); check("t6 round1", v, 32'h0000_0000);
        capture(v); check("t6 round2", v, 32'h0000_0000);
        capture(v); check("t6 round3", v, 32'h0000_0000);
        check("t6 busy idle", 32'(busy), 32'd0);

        // Random traffic, including a stretch without zero pulses.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            zero_en = !(i >= 700 && i < 800);
            tick($urandom_range(0, 5) == 0, 3'($urandom), 4'($urandom), $urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
